// File: rtl/mult_bcd_scheduler_pkg.sv
// Shared types and sizing helpers for the multiply/BCD scheduler.
package mult_bcd_sched_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        BCD,
        RESP
    } state_t;

    localparam int unsigned N_DEF      = 8;
    localparam int unsigned MUL_CYCLES = N_DEF;
    localparam int unsigned BCD_CYCLES = 2 * N_DEF;

    // One multiplier bit is consumed per MUL cycle.
    function automatic int unsigned mul_cycles(input int unsigned n);
        return n;
    endfunction

    // One product bit is shifted into the BCD register per BCD cycle.
    function automatic int unsigned bcd_cycles(input int unsigned n);
        return 2 * n;
    endfunction

    // Smallest digit count d with 10^d > (2^n - 1)^2 (valid for n <= 31).
    function automatic int unsigned digits_required(input int unsigned n);
        longint unsigned maxp;
        longint unsigned lim;
        int unsigned     d;
        maxp = ((64'd1 << n) - 64'd1) * ((64'd1 << n) - 64'd1);
        lim  = 64'd1;
        d    = 0;
        while (lim <= maxp) begin
            lim = lim * 64'd10;
            d   = d + 1;
        end
        return d;
    endfunction

endpackage

// File: rtl/mult_bcd_scheduler_if.sv
// Requester/consumer bus of the multiply/BCD scheduler.
interface mult_bcd_scheduler_if #(
    parameter int unsigned N      = 8,
    parameter int unsigned NREQ   = 4,
    parameter int unsigned IDW    = (NREQ > 1) ? $clog2(NREQ) : 1,
    parameter int unsigned DIGITS = 5
);
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*N-1:0]   req_a;
    logic [NREQ*N-1:0]   req_b;
    logic                resp_valid;
    logic                resp_ready;
    logic [IDW-1:0]      resp_id;
    logic [2*N-1:0]      resp_product;
    logic [4*DIGITS-1:0] resp_bcd;
    logic                busy;

    modport master (
        output req_valid, req_a, req_b, resp_ready,
        input  req_ready, resp_valid, resp_id, resp_product, resp_bcd, busy
    );

    modport slave (
        input  req_valid, req_a, req_b, resp_ready,
        output req_ready, resp_valid, resp_id, resp_product, resp_bcd, busy
    );
endinterface

// File: rtl/mult_bcd_scheduler_core.sv
// Shift-add multiplier followed by a double-dabble binary-to-BCD converter.
module mult_bcd_core #(
    parameter int unsigned N      = 8,
    parameter int unsigned DIGITS = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                step_mul,
    input  logic                step_bcd,
    input  logic [N-1:0]        a,
    input  logic [N-1:0]        b,
    output logic [2*N-1:0]      product,
    output logic [4*DIGITS-1:0] bcd
);

    logic [2*N-1:0]      acc_q;
    logic [2*N-1:0]      mcand_q;
    logic [N-1:0]        mplier_q;
    logic [2*N-1:0]      bin_q;
    logic [4*DIGITS-1:0] bcd_q;

    logic [2*N-1:0]      acc_add;
    logic [4*DIGITS-1:0] bcd_adj;

    // Partial-product accumulate and per-digit add-3 correction.
    always_comb begin
        logic [3:0] dig;
        dig     = '0;
        acc_add = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
        bcd_adj = '0;
        for (int unsigned d = 0; d < DIGITS; d++) begin
            dig = bcd_q[4*d +: 4];
            bcd_adj[4*d +: 4] = (dig >= 4'd5) ? 4'(dig + 4'd3) : dig;
        end
    end

    // Datapath registers; bin_q mirrors the accumulator during MUL so the
    // BCD phase can shift it out while acc_q keeps the product intact.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            bin_q    <= '0;
            bcd_q    <= '0;
        end else if (start) begin
            acc_q    <= '0;
            mcand_q  <= {{N{1'b0}}, a};
            mplier_q <= b;
            bin_q    <= '0;
            bcd_q    <= '0;
        end else if (step_mul) begin
            acc_q    <= acc_add;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            bin_q    <= acc_add;
        end else if (step_bcd) begin
            bcd_q    <= {bcd_adj[4*DIGITS-2:0], bin_q[2*N-1]};
            bin_q    <= bin_q << 1;
        end
    end

    assign product = acc_q;
    assign bcd     = bcd_q;

endmodule

// File: rtl/mult_bcd_scheduler.sv
// Round-robin scheduler sharing one multiply/BCD core among NREQ requesters.
module mult_bcd_scheduler
    import mult_bcd_sched_pkg::*;
#(
    parameter int unsigned N      = 8,
    parameter int unsigned NREQ   = 4,
    parameter int unsigned IDW    = (NREQ > 1) ? $clog2(NREQ) : 1,
    parameter int unsigned DIGITS = digits_required(N)
) (
    input  logic                 clk,
    input  logic                 reset,
    mult_bcd_scheduler_if.slave  bus
);

    localparam int unsigned MUL_CNT = mul_cycles(N);
    localparam int unsigned BCD_CNT = bcd_cycles(N);
    localparam int unsigned CNTW    = $clog2(BCD_CNT + 1);

    state_t          state_q, state_d;
    logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [IDW-1:0]  id_q, id_d;

    logic            win_found;
    logic [IDW-1:0]  win_idx;
    logic [N-1:0]    sel_a, sel_b;
    logic [NREQ-1:0] ready_d;
    logic            start, step_mul, step_bcd;

    // Circular search for the first valid requester starting at rr_ptr.
    always_comb begin
        int unsigned idx;
        idx       = 0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = (32'(rr_ptr_q) + k) % NREQ;
            if (!win_found && bus.req_valid[idx]) begin
                win_found = 1'b1;
                win_idx   = IDW'(idx);
            end
        end
        sel_a = bus.req_a[32'(win_idx)*N +: N];
        sel_b = bus.req_b[32'(win_idx)*N +: N];
    end

    // Next-state, grant and core control.
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        cnt_d    = cnt_q;
        id_d     = id_q;
        ready_d  = '0;
        start    = 1'b0;
        step_mul = 1'b0;
        step_bcd = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (win_found) begin
                    ready_d  = NREQ'(1) << win_idx;
                    start    = 1'b1;
                    id_d     = win_idx;
                    rr_ptr_d = IDW'((32'(win_idx) + 1) % NREQ);
                    cnt_d    = '0;
                    state_d  = MUL;
                end
            end
            MUL: begin
                step_mul = 1'b1;
                if (cnt_q == CNTW'(MUL_CNT - 1)) begin
                    cnt_d   = '0;
                    state_d = BCD;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            BCD: begin
                step_bcd = 1'b1;
                if (cnt_q == CNTW'(BCD_CNT - 1)) begin
                    cnt_d   = '0;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                if (bus.resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, round-robin pointer, phase counter and owner ID.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            cnt_q    <= '0;
            id_q     <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
            id_q     <= id_d;
        end
    end

    mult_bcd_core #(
        .N      (N),
        .DIGITS (DIGITS)
    ) u_core (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .step_mul (step_mul),
        .step_bcd (step_bcd),
        .a        (sel_a),
        .b        (sel_b),
        .product  (bus.resp_product),
        .bcd      (bus.resp_bcd)
    );

    assign bus.req_ready  = ready_d;
    assign bus.resp_valid = (state_q == RESP);
    assign bus.resp_id    = id_q;
    assign bus.busy       = (state_q != IDLE);

endmodule
